// File: rtl/wb_stage_nlane_pkg.sv
// ---------------------------------------------------------------------------
// wb_stage_nlane_pkg
// Shared CPU defines used by the writeback stage:
//   load_type_e : load extension kinds carried down the pipe (3-bit code).
//                 Codes 5-7 are unused and pass the raw word through.
//   wb_sel_e    : source select for the register-file write data.
//   RF_AW       : register-file address width.
// ---------------------------------------------------------------------------
package wb_stage_nlane_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LB  = 3'd1,
    LBU = 3'd2,
    LH  = 3'd3,
    LHU = 3'd4
  } load_type_e;

  typedef enum logic [1:0] {
    WB_PCPLUS8 = 2'd0,
    WB_ALU     = 2'd1,
    WB_OUTB    = 2'd2,
    WB_LOAD    = 2'd3
  } wb_sel_e;

  localparam int RF_AW = 5;

endpackage

// File: rtl/wb_stage_nlane_load_ext.sv
// ---------------------------------------------------------------------------
// wb_load_ext
// Combinational load alignment / extension for one writeback lane.
// Memory words are little-endian: byte k lives at dmout[8k+7:8k].
// Ports:
//   loadtype_i [2:0]   load kind (load_type_e encoding, 5-7 = full word)
//   addr_lo_i  [1:0]   low address bits (aluout[1:0]); bit 0 unused for halves
//   dmout_i    [DW-1:0] raw memory word
//   ldata_o    [DW-1:0] extended load result
// ---------------------------------------------------------------------------
module wb_load_ext
  import wb_stage_nlane_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    loadtype_i,
  input  logic [1:0]    addr_lo_i,
  input  logic [DW-1:0] dmout_i,
  output logic [DW-1:0] ldata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = dmout_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = dmout_i[{addr_lo_i[1], 4'b0000} +: 16];
    ldata_o  = dmout_i;
    case (loadtype_i)
      LB:      ldata_o = {{(DW-8){byte_sel[7]}}, byte_sel};
      LBU:     ldata_o = {{(DW-8){1'b0}}, byte_sel};
      LH:      ldata_o = {{(DW-16){half_sel[15]}}, half_sel};
      LHU:     ldata_o = {{(DW-16){1'b0}}, half_sel};
      default: ldata_o = dmout_i;
    endcase
  end

endmodule

// File: rtl/wb_stage_nlane.sv
// ---------------------------------------------------------------------------
// wb_stage_nlane
// Multi-lane writeback stage. Holds one MEM->WB register per lane, produces
// register-file writes and counts retired instructions. Lane 0 is oldest.
// Ports:
//   clk, resetn (async, active-low)
//   wb_flush  : empty all lanes at the next edge (highest priority)
//   wb_wr     : capture the MEM inputs at the next edge
//   wb_diswr  : stall - suppress writes and retirement this cycle
//   mem_*     : per-lane MEM-stage fields, lane i in slice i
//   rf_we/rf_waddr/rf_wdata : register-file write ports, one per lane
//   wb_pc     : registered PC per lane
//   retire_cnt: committed-instruction counter (wraps at 2^32)
// ---------------------------------------------------------------------------
module wb_stage_nlane
  import wb_stage_nlane_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wb_flush,
  input  logic                  wb_wr,
  input  logic                  wb_diswr,
  input  logic [LANES-1:0]      mem_valid,
  input  logic [LANES-1:0]      mem_rfwr,
  input  logic [LANES*5-1:0]    mem_dst,
  input  logic [LANES*2-1:0]    mem_wbsel,
  input  logic [LANES*3-1:0]    mem_loadtype,
  input  logic [LANES*DW-1:0]   mem_pc,
  input  logic [LANES*DW-1:0]   mem_aluout,
  input  logic [LANES*DW-1:0]   mem_outb,
  input  logic [LANES*DW-1:0]   mem_dmout,
  output logic [LANES-1:0]      rf_we,
  output logic [LANES*5-1:0]    rf_waddr,
  output logic [LANES*DW-1:0]   rf_wdata,
  output logic [LANES*DW-1:0]   wb_pc,
  output logic [31:0]           retire_cnt
);

  logic [LANES-1:0]    valid_q, committed_q, committed_d, rfwr_q;
  logic [LANES*5-1:0]  dst_q;
  logic [LANES*2-1:0]  wbsel_q;
  logic [LANES*3-1:0]  loadtype_q;
  logic [LANES*DW-1:0] pc_q, aluout_q, outb_q, dmout_q;
  logic [31:0]         retire_cnt_q, retire_cnt_d;

  logic [LANES-1:0]    retire;
  logic [LANES-1:0]    we_raw;
  logic [31:0]         retire_sum;

  // A lane retires once: the committed flag blocks re-retiring while held.
  assign retire = valid_q & ~committed_q & {LANES{~wb_diswr}};

  // Younger lanes override older ones writing the same register. Comparing
  // against the raw strobes is sufficient: if a younger lane is itself
  // overridden, the lane overriding it also matches the older lane's dst.
  always_comb begin
    rf_we = '0;
    for (int i = 0; i < LANES; i++) begin
      rf_we[i] = we_raw[i];
      for (int j = i + 1; j < LANES; j++) begin
        if (we_raw[j] && (dst_q[j*RF_AW +: RF_AW] == dst_q[i*RF_AW +: RF_AW]))
          rf_we[i] = 1'b0;
      end
    end
  end

  always_comb begin
    retire_sum = '0;
    for (int i = 0; i < LANES; i++)
      retire_sum = retire_sum + 32'(retire[i]);
    retire_cnt_d = retire_cnt_q + retire_sum;
  end

  // Committed only accumulates while the register holds; a flush or a new
  // capture always starts the lane fresh.
  always_comb begin
    committed_d = committed_q | retire;
    if (wb_flush || wb_wr)
      committed_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q      <= '0;
      committed_q  <= '0;
      rfwr_q       <= '0;
      dst_q        <= '0;
      wbsel_q      <= '0;
      loadtype_q   <= '0;
      pc_q         <= '0;
      aluout_q     <= '0;
      outb_q       <= '0;
      dmout_q      <= '0;
      retire_cnt_q <= '0;
    end else begin
      // Retirement in the current cycle counts even when flushing.
      retire_cnt_q <= retire_cnt_d;
      committed_q  <= committed_d;
      if (wb_flush) begin
        valid_q <= '0;
      end else if (wb_wr) begin
        valid_q    <= mem_valid;
        rfwr_q     <= mem_rfwr;
        dst_q      <= mem_dst;
        wbsel_q    <= mem_wbsel;
        loadtype_q <= mem_loadtype;
        pc_q       <= mem_pc;
        aluout_q   <= mem_aluout;
        outb_q     <= mem_outb;
        dmout_q    <= mem_dmout;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [DW-1:0] load_data;
      logic [DW-1:0] sel_data;

      wb_load_ext #(.DW(DW)) u_load_ext (
        .loadtype_i (loadtype_q[gi*3 +: 3]),
        .addr_lo_i  (aluout_q[gi*DW +: 2]),
        .dmout_i    (dmout_q[gi*DW +: DW]),
        .ldata_o    (load_data)
      );

      assign we_raw[gi] = retire[gi] & rfwr_q[gi] &
                          (dst_q[gi*RF_AW +: RF_AW] != '0);

      always_comb begin
        sel_data = '0;
        case (wbsel_q[gi*2 +: 2])
          WB_PCPLUS8: sel_data = pc_q[gi*DW +: DW] + DW'(8);
          WB_ALU:     sel_data = aluout_q[gi*DW +: DW];
          WB_OUTB:    sel_data = outb_q[gi*DW +: DW];
          default:    sel_data = load_data;
        endcase
      end

      // Empty lanes drive zero data so a reset or flushed stage is quiet.
      assign rf_wdata[gi*DW +: DW]       = valid_q[gi] ? sel_data : '0;
      assign rf_waddr[gi*RF_AW +: RF_AW] = dst_q[gi*RF_AW +: RF_AW];
      assign wb_pc[gi*DW +: DW]          = pc_q[gi*DW +: DW];
    end
  endgenerate

  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage_nlane.sv
// ---------------------------------------------------------------------------
// tb_wb_stage_nlane
// Directed bench for wb_stage_nlane (LANES=2, DW=32). Inputs change 1 time
// unit after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_wb_stage_nlane;

  localparam int LANES = 2;
  localparam int DW    = 32;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              wb_flush = 1'b0;
  logic              wb_wr = 1'b0;
  logic              wb_diswr = 1'b0;
  logic [1:0]        mem_valid = '0;
  logic [1:0]        mem_rfwr = '0;
  logic [9:0]        mem_dst = '0;
  logic [3:0]        mem_wbsel = '0;
  logic [5:0]        mem_loadtype = '0;
  logic [63:0]       mem_pc = '0;
  logic [63:0]       mem_aluout = '0;
  logic [63:0]       mem_outb = '0;
  logic [63:0]       mem_dmout = '0;
  logic [1:0]        rf_we;
  logic [9:0]        rf_waddr;
  logic [63:0]       rf_wdata;
  logic [63:0]       wb_pc;
  logic [31:0]       retire_cnt;

  int checks = 0;
  int errors = 0;

  wb_stage_nlane #(.LANES(LANES), .DW(DW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wb_flush     (wb_flush),
    .wb_wr        (wb_wr),
    .wb_diswr     (wb_diswr),
    .mem_valid    (mem_valid),
    .mem_rfwr     (mem_rfwr),
    .mem_dst      (mem_dst),
    .mem_wbsel    (mem_wbsel),
    .mem_loadtype (mem_loadtype),
    .mem_pc       (mem_pc),
    .mem_aluout   (mem_aluout),
    .mem_outb     (mem_outb),
    .mem_dmout    (mem_dmout),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .wb_pc        (wb_pc),
    .retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic v, input logic w,
                          input logic [4:0] d, input logic [1:0] ws,
                          input logic [2:0] lt, input logic [31:0] p,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] m);
    mem_valid[l]           = v;
    mem_rfwr[l]            = w;
    mem_dst[l*5 +: 5]      = d;
    mem_wbsel[l*2 +: 2]    = ws;
    mem_loadtype[l*3 +: 3] = lt;
    mem_pc[l*32 +: 32]     = p;
    mem_aluout[l*32 +: 32] = a;
    mem_outb[l*32 +: 32]   = b;
    mem_dmout[l*32 +: 32]  = m;
  endtask

  task automatic capture;
    wb_wr = 1'b1;
    tick();
    wb_wr = 1'b0;
  endtask

  task automatic test_reset;
    tick();
    tick();
    checks++;
    if (rf_we !== 2'b00) begin
      errors++; $display("FAIL reset_we: got %b expected 00", rf_we);
    end
    checks++;
    if (retire_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_cnt: got %h expected 00000000", retire_cnt);
    end
    checks++;
    if (rf_wdata !== 64'h0 || wb_pc !== 64'h0 || rf_waddr !== 10'h0) begin
      errors++; $display("FAIL reset_data: got wdata %h pc %h waddr %h expected all 0",
                         rf_wdata, wb_pc, rf_waddr);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (retire_cnt !== 32'h0 || rf_we !== 2'b00) begin
      errors++; $display("FAIL reset_release: got cnt %h we %b expected 0/00", retire_cnt, rf_we);
    end
    $display("reset: done");
  endtask

  task automatic test_load_ext;
    set_lane(0, 1, 1, 5, 2'd3, 3'd1, 32'h100, 32'h1003, 32'h0, 32'h80FF_0000);
    set_lane(1, 0, 0, 0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    capture();
    checks++;
    if (rf_we !== 2'b01 || rf_wdata[31:0] !== 32'hFFFF_FF80 || rf_waddr[4:0] !== 5'd5) begin
      errors++; $display("FAIL lb_sext: got we %b data %h addr %0d expected 01 ffffff80 5",
                         rf_we, rf_wdata[31:0], rf_waddr[4:0]);
    end
    tick();
    checks++;
    if (retire_cnt !== 32'd1 || rf_we !== 2'b00) begin
      errors++; $display("FAIL lb_commit: got cnt %0d we %b expected 1 00", retire_cnt, rf_we);
    end
    $display("load LB: data %h cnt %0d", rf_wdata[31:0], retire_cnt);

    set_lane(0, 1, 1, 1, 2'd3, 3'd2, 32'h0, 32'h1002, 32'h0, 32'h80FF_0000);
    set_lane(1, 1, 1, 6, 2'd3, 3'd3, 32'h0, 32'h2003, 32'h0, 32'h8001_1234);
    capture();
    checks++;
    if (rf_wdata !== {32'hFFFF_8001, 32'h0000_00FF} || rf_we !== 2'b11) begin
      errors++; $display("FAIL lbu_lh: got %h we %b expected ffff8001000000ff 11", rf_wdata, rf_we);
    end
    tick();
    $display("load LBU/LH: data %h cnt %0d", rf_wdata, retire_cnt);

    set_lane(0, 1, 1, 1, 2'd3, 3'd4, 32'h0, 32'h0, 32'h0, 32'h1234_F00D);
    set_lane(1, 1, 1, 2, 2'd3, 3'd5, 32'h0, 32'h1, 32'h0, 32'hDEAD_BEEF);
    capture();
    checks++;
    if (rf_wdata !== {32'hDEAD_BEEF, 32'h0000_F00D}) begin
      errors++; $display("FAIL lhu_code5: got %h expected deadbeef0000f00d", rf_wdata);
    end
    tick();
    checks++;
    if (retire_cnt !== 32'd5) begin
      errors++; $display("FAIL load_cnt: got %0d expected 5", retire_cnt);
    end
    $display("load LHU/code5: data %h cnt %0d", rf_wdata, retire_cnt);
  endtask

  task automatic test_wbsel;
    set_lane(0, 1, 0, 8, 2'd0, 3'd0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0);
    set_lane(1, 1, 1, 0, 2'd1, 3'd0, 32'h40, 32'h1234, 32'h0, 32'h0);
    capture();
    checks++;
    if (rf_we !== 2'b00 || rf_wdata !== {32'h0000_1234, 32'h0000_0004}) begin
      errors++; $display("FAIL pc8_nowrite: got we %b data %h expected 00 0000123400000004",
                         rf_we, rf_wdata);
    end
    checks++;
    if (wb_pc !== {32'h40, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL wb_pc: got %h expected 00000040fffffffc", wb_pc);
    end
    tick();
    checks++;
    if (retire_cnt !== 32'd7) begin
      errors++; $display("FAIL nowrite_count: got %0d expected 7", retire_cnt);
    end
    $display("wbsel pc+8/alu: data %h cnt %0d", rf_wdata, retire_cnt);

    set_lane(0, 1, 1, 3, 2'd2, 3'd0, 32'h0, 32'h0, 32'hCAFE_BABE, 32'h0);
    set_lane(1, 1, 1, 4, 2'd3, 3'd0, 32'h0, 32'h2, 32'h0, 32'h0102_0304);
    capture();
    checks++;
    if (rf_we !== 2'b11 || rf_wdata !== {32'h0102_0304, 32'hCAFE_BABE} ||
        rf_waddr !== {5'd4, 5'd3}) begin
      errors++; $display("FAIL outb_lw: got we %b data %h addr %h expected 11 01020304cafebabe 083",
                         rf_we, rf_wdata, rf_waddr);
    end
    tick();
    $display("wbsel outb/lw: data %h cnt %0d", rf_wdata, retire_cnt);
  endtask

  task automatic test_same_dst;
    set_lane(0, 1, 1, 7, 2'd1, 3'd0, 32'h0, 32'h11, 32'h0, 32'h0);
    set_lane(1, 1, 1, 7, 2'd1, 3'd0, 32'h0, 32'h22, 32'h0, 32'h0);
    capture();
    checks++;
    if (rf_we !== 2'b10 || rf_wdata[63:32] !== 32'h22 || rf_waddr[9:5] !== 5'd7) begin
      errors++; $display("FAIL same_dst: got we %b data1 %h addr1 %0d expected 10 00000022 7",
                         rf_we, rf_wdata[63:32], rf_waddr[9:5]);
    end
    tick();
    checks++;
    if (retire_cnt !== 32'd11) begin
      errors++; $display("FAIL same_dst_cnt: got %0d expected 11", retire_cnt);
    end
    $display("same dst: cnt %0d", retire_cnt);
  endtask

  task automatic test_hold;
    int pulses;
    pulses = 0;
    set_lane(0, 1, 1, 9, 2'd1, 3'd0, 32'h0, 32'h55, 32'h0, 32'h0);
    set_lane(1, 0, 0, 0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    capture();
    for (int c = 0; c < 3; c++) begin
      if (rf_we[0]) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL hold_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (retire_cnt !== 32'd12) begin
      errors++; $display("FAIL hold_cnt: got %0d expected 12", retire_cnt);
    end
    $display("hold 3 cycles: pulses %0d cnt %0d", pulses, retire_cnt);
  endtask

  task automatic test_stall;
    set_lane(0, 1, 1, 12, 2'd1, 3'd0, 32'h0, 32'h77, 32'h0, 32'h0);
    wb_diswr = 1'b1;
    capture();
    checks++;
    if (rf_we !== 2'b00) begin
      errors++; $display("FAIL stall_we1: got %b expected 00", rf_we);
    end
    tick();
    checks++;
    if (rf_we !== 2'b00 || retire_cnt !== 32'd12) begin
      errors++; $display("FAIL stall_we2: got we %b cnt %0d expected 00 12", rf_we, retire_cnt);
    end
    wb_diswr = 1'b0;
    #1;
    checks++;
    if (rf_we !== 2'b01 || rf_wdata[31:0] !== 32'h77) begin
      errors++; $display("FAIL stall_release: got we %b data %h expected 01 00000077",
                         rf_we, rf_wdata[31:0]);
    end
    tick();
    checks++;
    if (rf_we !== 2'b00 || retire_cnt !== 32'd13) begin
      errors++; $display("FAIL stall_after: got we %b cnt %0d expected 00 13", rf_we, retire_cnt);
    end
    $display("stall: cnt %0d", retire_cnt);
  endtask

  task automatic test_wrap;
    set_lane(0, 1, 1, 13, 2'd1, 3'd0, 32'h0, 32'h1, 32'h0, 32'h0);
    set_lane(1, 1, 1, 14, 2'd1, 3'd0, 32'h0, 32'h2, 32'h0, 32'h0);
    capture();
    // Jump the counter near its top; the pair now waiting retires next edge.
    force dut.retire_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.retire_cnt_q;
    capture();
    checks++;
    if (retire_cnt !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_pre: got %h expected ffffffff", retire_cnt);
    end
    tick();
    checks++;
    if (retire_cnt !== 32'h0000_0001) begin
      errors++; $display("FAIL wrap: got %h expected 00000001", retire_cnt);
    end
    $display("wrap: cnt %h", retire_cnt);
  endtask

  task automatic test_flush_reset;
    set_lane(0, 1, 1, 10, 2'd1, 3'd0, 32'h0, 32'hA, 32'h0, 32'h0);
    set_lane(1, 1, 1, 11, 2'd1, 3'd0, 32'h0, 32'hB, 32'h0, 32'h0);
    capture();
    checks++;
    if (rf_we !== 2'b11) begin
      errors++; $display("FAIL pre_flush_we: got %b expected 11", rf_we);
    end
    set_lane(0, 1, 1, 15, 2'd1, 3'd0, 32'h0, 32'hF, 32'h0, 32'h0);
    wb_flush = 1'b1;
    wb_wr    = 1'b1;
    tick();
    wb_flush = 1'b0;
    wb_wr    = 1'b0;
    checks++;
    if (rf_we !== 2'b00 || rf_wdata !== 64'h0 || retire_cnt !== 32'd3) begin
      errors++; $display("FAIL flush: got we %b data %h cnt %0d expected 00 0 3",
                         rf_we, rf_wdata, retire_cnt);
    end
    tick();
    checks++;
    if (rf_we !== 2'b00 || retire_cnt !== 32'd3) begin
      errors++; $display("FAIL flush_hold: got we %b cnt %0d expected 00 3", rf_we, retire_cnt);
    end
    $display("flush+wr: cnt %0d", retire_cnt);

    set_lane(0, 1, 1, 20, 2'd1, 3'd0, 32'h300, 32'h99, 32'h0, 32'h0);
    set_lane(1, 0, 0, 0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    wb_diswr = 1'b1;
    capture();
    set_lane(0, 0, 0, 0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    resetn = 1'b0;
    #1;
    checks++;
    if (retire_cnt !== 32'h0 || rf_we !== 2'b00 || rf_wdata !== 64'h0 ||
        wb_pc !== 64'h0 || rf_waddr !== 10'h0) begin
      errors++; $display("FAIL async_reset: got cnt %h we %b data %h pc %h addr %h expected all 0",
                         retire_cnt, rf_we, rf_wdata, wb_pc, rf_waddr);
    end
    wb_diswr = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    checks++;
    if (rf_we !== 2'b00 || retire_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_discard: got we %b cnt %0d expected 00 0", rf_we, retire_cnt);
    end
    $display("reset mid-stall: cnt %0d", retire_cnt);
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_wbsel();
    test_same_dst();
    test_hold();
    test_stall();
    test_wrap();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
